// File: rtl/lab2_proc_mem_arbiter_pkg.sv
// Shared types for the processor memory arbiter.
// Memory message formats, source tags and a line-trace helper.
package lab2_proc_mem_arbiter_pkg;

    typedef enum logic {
        MEMARB_SRC_IMEM = 1'b0,
        MEMARB_SRC_DMEM = 1'b1
    } memarb_src_e;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    localparam int MEMARB_TRACE_W = 8 * 6;

    // Six characters: grant, space, two-digit inflight, space, response.
    function automatic logic [MEMARB_TRACE_W-1:0] memarb_trace(
        input logic        grant_val,
        input memarb_src_e grant_src,
        input logic [4:0]  count,
        input logic        resp_i,
        input logic        resp_d
    );
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] tens;
        logic [7:0] ones;
        g = " ";
        if (grant_val) begin
            g = (grant_src == MEMARB_SRC_IMEM) ? "I" : "D";
        end
        r = " ";
        if (resp_i) begin
            r = "I";
        end else if (resp_d) begin
            r = "D";
        end
        tens = 8'h30 + 8'(count / 5'd10);
        ones = 8'h30 + 8'(count % 5'd10);
        return {g, 8'h20, tens, ones, 8'h20, r};
    endfunction

endpackage

// File: rtl/lab2_proc_mem_arbiter_tag_fifo.sv
// In-order FIFO of request source tags.
// One entry per outstanding memory request.
module lab2_proc_mem_arbiter_tag_fifo
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  memarb_src_e              push_tag,
    input  logic                     pop,
    output memarb_src_e              head_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(p_depth):0] count
);

    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(p_depth);

    logic [p_depth-1:0] tags;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_tag = memarb_src_e'(tags[rd_ptr]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lab2_proc_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between imem and dmem.
// Responses are routed back in issue order using a tag FIFO.
module lab2_proc_mem_arbiter
    import lab2_proc_mem_arbiter_pkg::*;
#(
    parameter int p_max_inflight = 4
) (
    input  logic                            clk,
    input  logic                            reset,

    input  mem_req_4B_t                     imemreq_msg,
    input  logic                            imemreq_val,
    output logic                            imemreq_rdy,

    input  mem_req_4B_t                     dmemreq_msg,
    input  logic                            dmemreq_val,
    output logic                            dmemreq_rdy,

    output mem_req_4B_t                     memreq_msg,
    output logic                            memreq_val,
    input  logic                            memreq_rdy,

    input  mem_resp_4B_t                    memresp_msg,
    input  logic                            memresp_val,
    output logic                            memresp_rdy,

    output mem_resp_4B_t                    imemresp_msg,
    output logic                            imemresp_val,
    input  logic                            imemresp_rdy,

    output mem_resp_4B_t                    dmemresp_msg,
    output logic                            dmemresp_val,
    input  logic                            dmemresp_rdy,

    output logic [$clog2(p_max_inflight):0] inflight,
    output logic                            err_unexpected_resp
);

    memarb_src_e prio;
    memarb_src_e grant_src;
    memarb_src_e head_tag;
    logic        full;
    logic        empty;
    logic        memreq_fire;
    logic        memresp_fire;
    logic        route_i;
    logic        route_d;

    always_comb begin
        grant_src = MEMARB_SRC_IMEM;
        unique case (1'b1)
            imemreq_val && dmemreq_val:  grant_src = prio;
            !imemreq_val && dmemreq_val: grant_src = MEMARB_SRC_DMEM;
            default:                     grant_src = MEMARB_SRC_IMEM;
        endcase
    end

    // Full is registered, so a same-cycle pop never re-opens the grant.
    assign memreq_val  = (imemreq_val || dmemreq_val) && !full && !reset;
    assign memreq_msg  = (grant_src == MEMARB_SRC_IMEM) ? imemreq_msg
                                                        : dmemreq_msg;
    assign memreq_fire = memreq_val && memreq_rdy;

    assign imemreq_rdy = memreq_fire && (grant_src == MEMARB_SRC_IMEM);
    assign dmemreq_rdy = memreq_fire && (grant_src == MEMARB_SRC_DMEM);

    assign route_i = !reset && !empty && (head_tag == MEMARB_SRC_IMEM);
    assign route_d = !reset && !empty && (head_tag == MEMARB_SRC_DMEM);

    // With nothing outstanding the response is accepted and dropped.
    always_comb begin
        memresp_rdy = 1'b1;
        unique case (1'b1)
            route_i: memresp_rdy = imemresp_rdy;
            route_d: memresp_rdy = dmemresp_rdy;
            default: memresp_rdy = 1'b1;
        endcase
    end

    assign imemresp_val = memresp_val && route_i;
    assign dmemresp_val = memresp_val && route_d;
    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;
    assign memresp_fire = memresp_val && memresp_rdy && !empty;

    lab2_proc_mem_arbiter_tag_fifo #(
        .p_depth  (p_max_inflight)
    ) tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (memreq_fire),
        .push_tag (grant_src),
        .pop      (memresp_fire),
        .head_tag (head_tag),
        .full     (full),
        .empty    (empty),
        .count    (inflight)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio                <= MEMARB_SRC_IMEM;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (memreq_fire) begin
                prio <= (grant_src == MEMARB_SRC_IMEM) ? MEMARB_SRC_DMEM
                                                       : MEMARB_SRC_IMEM;
            end
            if (memresp_val && empty) begin
                err_unexpected_resp <= 1'b1;
            end
        end
    end

endmodule
